add_rec_fn: RTL and testbench

- Single-cycle-registered IEEE-754 floating-point adder/subtractor, binary32 by default.
- Computes a + b, or a − b when sub_op=1, with selectable rounding mode and a tininess-detection control.
- Produces the result and five IEEE exception flags.
- Arithmetic leaf block in the FPU datapath; all operands and the result use the standard IEEE interchange encoding (sign|exponent|fraction).

---
 rtl/add_rec_fn.sv | 127 ++++++++++++
 tb/tb_add_rec_fn.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/add_rec_fn.sv
// add_rec_fn: registered IEEE-754 adder/subtractor with rounding modes and exception flags
module add_rec_fn #(
  parameter int EXP_WIDTH = 8,
  parameter int SIG_WIDTH = 23
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           control,
  input  logic                           sub_op,
  input  logic [EXP_WIDTH+SIG_WIDTH:0]   a,
  input  logic [EXP_WIDTH+SIG_WIDTH:0]   b,
  input  logic [2:0]                     rounding_mode,
  output logic [EXP_WIDTH+SIG_WIDTH:0]   out,
  output logic [4:0]                     exception_flags
);
  localparam int E  = EXP_WIDTH;
  localparam int S  = SIG_WIDTH;
  localparam int W  = 1 + E + S;
  localparam int MW = S + 4;
  localparam int LW = $clog2(MW + 1);
  localparam int XW = (E > LW ? E : LW) + 2;
  localparam logic [W-1:0]   QNAN = {1'b0, {E{1'b1}}, 1'b1, {(S-1){1'b0}}};
  localparam logic [W-2:0]   INF  = {{E{1'b1}}, {S{1'b0}}};
  localparam logic [W-2:0]   MAXF = {{(E-1){1'b1}}, 1'b0, {S{1'b1}}};

  function automatic logic round_inc(input logic [2:0] rm, input logic sgn, input logic lsb,
                                     input logic g, input logic st);
    return (rm == 3'b001 || rm == 3'b110) ? 1'b0 :
           (rm == 3'b010) ? sgn & (g | st) :
           (rm == 3'b011) ? !sgn & (g | st) :
           (rm == 3'b100) ? g : g & (st | lsb);
  endfunction

  logic          sa, sb, sl, eff_sub, swap;
  logic [E-1:0]  ea, eb;
  logic [S-1:0]  fa, fb;
  logic          a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, inv, any_nan;
  logic [XW-1:0] ea_n, eb_n, el, es, d, lz, lsh, ex;
  logic [S:0]    ma, mb, ml, ms;
  logic [MW-1:0] xs, sh_r, al, n;
  logic          stk;
  logic [MW:0]   sum;
  logic [E:0]    ex_enc;
  logic          inexact_r, inc, inc2, tiny, ovf, to_inf;
  logic [W-1:0]  rnd;
  logic [W-2:0]  mag_o;
  logic [W-1:0]  out_d, out_q;
  logic [4:0]    flags_d, flags_q;

  // Leading-zero count of the unnormalized magnitude sum (MW when the sum is zero)
  always_comb begin
    lz = XW'(MW);
    for (int i = 0; i < MW; i++)
      if (sum[i]) lz = XW'(MW - 1 - i);
  end

  // Unpack, align, add, normalize, round and select special-case results
  always_comb begin
    sa        = a[W-1];
    sb        = b[W-1] ^ sub_op;
    ea        = a[W-2:S];
    eb        = b[W-2:S];
    fa        = a[S-1:0];
    fb        = b[S-1:0];
    a_nan     = (&ea) & (|fa);
    b_nan     = (&eb) & (|fb);
    a_snan    = a_nan & !fa[S-1];
    b_snan    = b_nan & !fb[S-1];
    a_inf     = (&ea) & !(|fa);
    b_inf     = (&eb) & !(|fb);
    eff_sub   = sa ^ sb;
    inv       = a_snan | b_snan | (a_inf & b_inf & eff_sub);
    any_nan   = a_nan | b_nan;
    ea_n      = (ea == '0) ? XW'(1) : XW'(ea);
    eb_n      = (eb == '0) ? XW'(1) : XW'(eb);
    ma        = {|ea, fa};
    mb        = {|eb, fb};
    swap      = b[W-2:0] > a[W-2:0];
    sl        = swap ? sb : sa;
    el        = swap ? eb_n : ea_n;
    es        = swap ? ea_n : eb_n;
    ml        = swap ? mb : ma;
    ms        = swap ? ma : mb;
    d         = el - es;
    xs        = {ms, 3'b000};
    sh_r      = xs >> d;
    stk       = |(xs & ~({MW{1'b1}} << d));
    al        = {sh_r[MW-1:1], sh_r[0] | stk};
    sum       = eff_sub ? {1'b0, ml, 3'b000} - {1'b0, al} : {1'b0, ml, 3'b000} + {1'b0, al};
    lsh       = (lz < el - XW'(1)) ? lz : el - XW'(1);
    n         = sum[MW] ? {sum[MW:2], |sum[1:0]} : sum[MW-1:0] << lsh;
    ex        = sum[MW] ? el + XW'(1) : el - lsh;
    ex_enc    = n[MW-1] ? (E+1)'(ex) : '0;
    inexact_r = |n[2:0];
    inc       = round_inc(rounding_mode, sl, n[3], n[2], |n[1:0]);
    inc2      = round_inc(rounding_mode, sl, n[2], n[1], n[0]);
    rnd       = {ex_enc, n[MW-2:3]} + W'(inc);
    mag_o     = {rnd[W-2:1], rnd[0] | ((rounding_mode == 3'b110) & inexact_r)};
    ovf       = rnd[W-1:S] >= {1'b0, {E{1'b1}}};
    tiny      = !n[MW-1] & (!control | !((&n[MW-2:2]) & inc2));
    to_inf    = (rounding_mode == 3'b010) ? sl :
                (rounding_mode == 3'b011) ? !sl :
                !(rounding_mode == 3'b001 || rounding_mode == 3'b110);
    out_d     = (any_nan | inv) ? QNAN :
                a_inf ? {sa, INF} :
                b_inf ? {sb, INF} :
                (sum == '0) ? {eff_sub ? (rounding_mode == 3'b010) : sa, {(W-1){1'b0}}} :
                ovf ? {sl, to_inf ? INF : MAXF} : {sl, mag_o};
    flags_d   = (any_nan | inv | a_inf | b_inf) ? {inv, 4'b0000} :
                (sum == '0) ? 5'b00000 :
                {2'b00, ovf, tiny & inexact_r & !ovf, inexact_r | ovf};
  end

  // Result and flag registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      flags_q <= '0;
    end else begin
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

  assign out             = out_q;
  assign exception_flags = flags_q;
endmodule

// File: tb/tb_add_rec_fn.sv
// tb_add_rec_fn: directed vectors with a queue scoreboard for add_rec_fn (binary32)
module tb_add_rec_fn;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        control = 1'b0;
  logic        sub_op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  rounding_mode = 3'b000;
  logic [31:0] out;
  logic [4:0]  exception_flags;

  typedef struct {
    logic        ctl;
    logic        sub;
    logic [2:0]  rm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eo;
    logic [4:0]  ef;
  } vec_t;

  typedef struct {
    logic [31:0] eo;
    logic [4:0]  ef;
    int          id;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  exp_t mon_e;
  logic vld = 1'b0;
  logic mon_v;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  add_rec_fn dut (
    .clk(clk),
    .rst_n(rst_n),
    .control(control),
    .sub_op(sub_op),
    .a(a),
    .b(b),
    .rounding_mode(rounding_mode),
    .out(out),
    .exception_flags(exception_flags)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, req);
    end
  endtask

  task automatic add_vec(input logic ctl, input logic sub, input logic [2:0] rm,
                         input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] eo, input logic [4:0] ef);
    vec_t v;
    v.ctl = ctl; v.sub = sub; v.rm = rm; v.a = va; v.b = vb; v.eo = eo; v.ef = ef;
    vecs.push_back(v);
  endtask

  task automatic drive(input int id);
    exp_t e;
    control       = vecs[id].ctl;
    sub_op        = vecs[id].sub;
    rounding_mode = vecs[id].rm;
    a             = vecs[id].a;
    b             = vecs[id].b;
    vld           = 1'b1;
    e.eo = vecs[id].eo;
    e.ef = vecs[id].ef;
    e.id = id;
    sb_q.push_back(e);
  endtask

  // Monitor: one cycle after a vector is driven, its result is on the outputs
  always @(posedge clk) begin
    mon_v = vld;
    #1;
    if (mon_v) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output got=%h want=none", out);
      end else begin
        mon_e = sb_q.pop_front();
        chk($sformatf("out[%0d]", mon_e.id), out, mon_e.eo);
        chk($sformatf("flags[%0d]", mon_e.id), {27'b0, exception_flags}, {27'b0, mon_e.ef});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    add_vec(0, 0, 3'b000, 32'h3F800000, 32'h3F800000, 32'h40000000, 5'b00000);
    add_vec(0, 1, 3'b000, 32'h3F800000, 32'h3F800000, 32'h00000000, 5'b00000);
    add_vec(0, 1, 3'b010, 32'h3F800000, 32'h3F800000, 32'h80000000, 5'b00000);
    add_vec(0, 1, 3'b000, 32'h43FA0000, 32'h437A0000, 32'h437A0000, 5'b00000);
    add_vec(0, 0, 3'b000, 32'h43FA0000, 32'h437A0000, 32'h443B8000, 5'b00000);
    add_vec(0, 0, 3'b000, 32'h3F800000, 32'h33800000, 32'h3F800000, 5'b00001);
    add_vec(0, 0, 3'b100, 32'h3F800000, 32'h33800000, 32'h3F800001, 5'b00001);
    add_vec(0, 0, 3'b011, 32'h3F800000, 32'h33800000, 32'h3F800001, 5'b00001);
    add_vec(0, 0, 3'b110, 32'h3F800000, 32'h33800000, 32'h3F800001, 5'b00001);
    add_vec(0, 0, 3'b001, 32'h3F800000, 32'h33800000, 32'h3F800000, 5'b00001);
    add_vec(0, 0, 3'b000, 32'h3F800001, 32'h33800000, 32'h3F800002, 5'b00001);
    add_vec(0, 0, 3'b000, 32'h3F800000, 32'h33C00000, 32'h3F800001, 5'b00001);
    add_vec(0, 0, 3'b010, 32'h3F800000, 32'h33C00000, 32'h3F800000, 5'b00001);
    add_vec(0, 1, 3'b000, 32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 5'b00000);
    add_vec(0, 0, 3'b000, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 5'b00101);
    add_vec(0, 0, 3'b001, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 5'b00101);
    add_vec(0, 0, 3'b010, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 5'b00101);
    add_vec(0, 0, 3'b011, 32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF7FFFFF, 5'b00101);
    add_vec(0, 0, 3'b010, 32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000, 5'b00101);
    add_vec(0, 1, 3'b000, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b10000);
    add_vec(0, 0, 3'b000, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 5'b00000);
    add_vec(0, 0, 3'b000, 32'h7F800001, 32'h00000000, 32'h7FC00000, 5'b10000);
    add_vec(0, 0, 3'b000, 32'h7F800000, 32'h3F800000, 32'h7F800000, 5'b00000);
    add_vec(0, 1, 3'b000, 32'hFF800000, 32'h3F800000, 32'hFF800000, 5'b00000);
    add_vec(1, 1, 3'b000, 32'h00800000, 32'h00800001, 32'h80000001, 5'b00000);
    add_vec(0, 0, 3'b000, 32'h80000000, 32'h80000000, 32'h80000000, 5'b00000);
    add_vec(0, 0, 3'b000, 32'h00000000, 32'h80000000, 32'h00000000, 5'b00000);

    repeat (2) @(negedge clk);
    chk("reset_out", out, 32'h0);
    chk("reset_flags", {27'b0, exception_flags}, 32'h0);
    rst_n = 1'b1;
    drive(0);
    @(negedge clk);
    vld = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", out, 32'h0);
    chk("async_rst_flags", {27'b0, exception_flags}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i < vecs.size(); i++) begin
      drive(i);
      @(negedge clk);
    end
    vld = 1'b0;
    for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge clk);
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d want=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
